// File: rtl/keypad_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : keypad_pkg
// Brief   : Shared keypad geometry, scan FSM state type and index helper.
// Revision: 1.0 - initial release
// ============================================================================
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } kp_state_t;

    // Index of the lowest zero bit; used for both row priority and column decode.
    function automatic logic [1:0] low_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scan_ctrl_sync2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : sync2
// Brief   : Two-flop synchronizer, resets to all-ones (idle pulled-up rows).
// Revision: 1.0 - initial release
// ============================================================================
module sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/keypad_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : keypad_scan_ctrl
// Brief   : 4x4 keypad column scanner with press/release debounce and
//           one-hot key strobe.
// Revision: 1.0 - initial release
// ============================================================================
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES     = 16,
    parameter int DEBOUNCE_CYCLES = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_ROWS-1:0]          rows,
    output logic [NUM_COLS-1:0]          cols,
    output logic                         new_key,
    output logic [NUM_ROWS*NUM_COLS-1:0] key_value
);

    localparam int c_max_cycles = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
    localparam int c_cnt_w      = $clog2(c_max_cycles);
    localparam int c_keys       = NUM_ROWS * NUM_COLS;

    localparam logic [c_cnt_w-1:0] c_scan_last = c_cnt_w'(SCAN_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_deb_last  = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic [NUM_ROWS-1:0] w_srows;

    kp_state_t           r_state;
    kp_state_t           w_state_nxt;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_cnt_w-1:0]  w_cnt_nxt;
    logic [NUM_COLS-1:0] r_cols;
    logic [NUM_COLS-1:0] w_cols_nxt;
    logic [1:0]          r_row;
    logic [1:0]          w_row_nxt;
    logic                r_new_key;
    logic                w_new_key_nxt;
    logic [c_keys-1:0]   r_key_value;
    logic [c_keys-1:0]   w_key_nxt;

    logic w_scan_done;
    logic w_deb_done;
    logic w_any_low;
    logic w_row_high;
    logic w_advance;

    sync2 #(
        .WIDTH (NUM_ROWS)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rows),
        .q     (w_srows)
    );

    assign w_scan_done = (r_cnt == c_scan_last);
    assign w_deb_done  = (r_cnt == c_deb_last);
    assign w_any_low   = ~&w_srows;
    assign w_row_high  = w_srows[r_row];

    // State and datapath register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= SCAN;
            r_cnt       <= '0;
            r_cols      <= 4'b1110;
            r_row       <= 2'd0;
            r_new_key   <= 1'b0;
            r_key_value <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cols      <= w_cols_nxt;
            r_row       <= w_row_nxt;
            r_new_key   <= w_new_key_nxt;
            r_key_value <= w_key_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SCAN: begin
                if (w_scan_done && w_any_low) w_state_nxt = DEBOUNCE;
            end
            DEBOUNCE: begin
                if (w_row_high)      w_state_nxt = SCAN;
                else if (w_deb_done) w_state_nxt = HELD;
            end
            HELD: begin
                if (w_row_high) w_state_nxt = RELEASE;
            end
            RELEASE: begin
                if (!w_row_high)     w_state_nxt = HELD;
                else if (w_deb_done) w_state_nxt = SCAN;
            end
            default: w_state_nxt = SCAN;
        endcase
    end

    // Output and datapath next values; the counter is parked at zero in HELD
    always_comb begin
        w_advance = ((r_state == SCAN) && w_scan_done && !w_any_low) ||
                    ((r_state != SCAN) && (w_state_nxt == SCAN));

        w_cols_nxt = w_advance ? {r_cols[NUM_COLS-2:0], r_cols[NUM_COLS-1]} : r_cols;

        w_row_nxt = ((r_state == SCAN) && (w_state_nxt == DEBOUNCE)) ? low_index(w_srows) : r_row;

        w_new_key_nxt = (r_state == DEBOUNCE) && (w_state_nxt == HELD);

        w_key_nxt = r_key_value;
        if (w_new_key_nxt) w_key_nxt = c_keys'(1) << {r_row, low_index(r_cols)};

        if ((w_state_nxt != r_state) || w_advance || (r_state == HELD)) w_cnt_nxt = '0;
        else                                                           w_cnt_nxt = r_cnt + 1'b1;
    end

    assign cols      = r_cols;
    assign new_key   = r_new_key;
    assign key_value = r_key_value;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_keypad_scan_ctrl
// Brief   : Directed self-checking bench for keypad_scan_ctrl with a keypad model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_keypad_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic        new_key;
    logic [15:0] key_value;

    logic [15:0] pressed = 16'h0000;   // bit r*4+c = key (r,c) held down

    int n_vec  = 0;
    int n_err  = 0;
    int pulses = 0;
    int doubles = 0;
    int base;
    logic prev_nk = 1'b0;

    logic [3:0] exp_cols [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    keypad_scan_ctrl #(
        .SCAN_CYCLES     (4),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rows      (rows),
        .cols      (cols),
        .new_key   (new_key),
        .key_value (key_value)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key shorts its row to its column while that column is driven low
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (new_key) begin
            pulses = pulses + 1;
            if (prev_nk) doubles = doubles + 1;
        end
        prev_nk = new_key;
    end

    task automatic check_vec(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_pulse(input string tag, input int target, input int budget);
        for (int k = 0; k < budget && pulses < target; k++) @(negedge clk);
        check_vec(tag, 16'(pulses), 16'(target));
    endtask

    task automatic wait_cols_eq(input string tag, input logic [3:0] target, input int budget);
        for (int k = 0; k < budget && cols !== target; k++) @(negedge clk);
        check_vec(tag, {12'h0, cols}, {12'h0, target});
    endtask

    task automatic wait_cols_change(input string tag, input logic [3:0] from, input logic [3:0] target, input int budget);
        for (int k = 0; k < budget && cols === from; k++) @(negedge clk);
        check_vec(tag, {12'h0, cols}, {12'h0, target});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_vec("rst_cols", {12'h0, cols}, 16'h000E);
        check_vec("rst_new_key", {15'h0, new_key}, 16'h0000);
        check_vec("rst_key_value", key_value, 16'h0000);

        // Idle scan: one column step every 4 clocks, starting on column 0
        reset = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            check_vec($sformatf("idle_cols_%0d", i), {12'h0, cols}, {12'h0, exp_cols[(i/4)%4]});
        end
        check_vec("idle_pulses", 16'(pulses), 16'd0);
        check_vec("idle_key_value", key_value, 16'h0000);

        // Clean press of (2,1), long hold, release resumes on column 2
        pressed = 16'h0200;
        wait_pulse("press21_pulse", 1, 200);
        check_vec("press21_key", key_value, 16'h0200);
        repeat (100) @(negedge clk);
        check_vec("press21_hold_pulses", 16'(pulses), 16'd1);
        check_vec("press21_hold_cols", {12'h0, cols}, 16'h000D);
        pressed = 16'h0000;
        wait_cols_change("press21_resume_col", 4'b1101, 4'b1011, 40);
        check_vec("press21_key_after_release", key_value, 16'h0200);

        // Short bounce on row 0 during debounce: no strobe, scan moves on
        repeat (10) @(negedge clk);
        pressed = 16'h0008;
        wait_cols_eq("bounce_reach_col3", 4'b0111, 40);
        repeat (5) @(posedge clk);
        @(negedge clk);
        pressed = 16'h0000;
        wait_cols_change("bounce_resume_col", 4'b0111, 4'b1110, 20);
        check_vec("bounce_pulses", 16'(pulses), 16'd1);
        check_vec("bounce_key", key_value, 16'h0200);

        pressed = 16'h0008;
        wait_pulse("press03_pulse", 2, 200);
        check_vec("press03_key", key_value, 16'h0008);
        pressed = 16'h0000;
        repeat (40) @(negedge clk);

        // Release bounce on (1,0)
        pressed = 16'h0010;
        wait_pulse("press10_pulse", 3, 200);
        repeat (5) @(negedge clk);
        pressed = 16'h0000;
        repeat (3) @(negedge clk);
        pressed = 16'h0010;
        repeat (20) @(negedge clk);
        pressed = 16'h0000;
        repeat (40) @(negedge clk);
        check_vec("relbounce_pulses", 16'(pulses), 16'd3);
        check_vec("relbounce_key", key_value, 16'h0010);

        // Simultaneous (1,2)+(3,2): lowest row wins; (0,0) ignored while held
        pressed = 16'h4040;
        wait_pulse("multi_pulse", 4, 200);
        check_vec("multi_key", key_value, 16'h0040);
        pressed = 16'h4041;
        repeat (40) @(negedge clk);
        check_vec("held_ignore_pulses", 16'(pulses), 16'd4);
        check_vec("held_ignore_key", key_value, 16'h0040);
        check_vec("held_ignore_cols", {12'h0, cols}, 16'h000B);
        pressed = 16'h0000;
        repeat (40) @(negedge clk);

        // Reset mid-debounce on (2,3): asynchronous clear, then a full new debounce
        pressed = 16'h0800;
        wait_cols_eq("rstdeb_reach_col3", 4'b0111, 40);
        repeat (6) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_vec("rstdeb_cols", {12'h0, cols}, 16'h000E);
        check_vec("rstdeb_new_key", {15'h0, new_key}, 16'h0000);
        check_vec("rstdeb_key", key_value, 16'h0000);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        base = pulses;
        repeat (20) @(negedge clk);
        check_vec("rstdeb_no_early", 16'(pulses), 16'(base));
        wait_pulse("rstdeb_pulse", base + 1, 60);
        check_vec("rstdeb_key_after", key_value, 16'h0800);
        pressed = 16'h0000;
        repeat (40) @(negedge clk);
        check_vec("no_double_strobe", 16'(doubles), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 Parameter SCAN_CYCLES, default 16: clocks each column is driven before its rows are sampled (legal range 2..65535).
REQ-002 Parameter DEBOUNCE_CYCLES, default 64: clocks a row level must stay stable to accept a press or a release (legal range 2..65535).
REQ-003 Port clk, input, 1: single system clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port rows, input, 4: raw keypad row pins, active-low (pulled up), asynchronous to clk.
REQ-006 Port cols, output, 4: column drives, active-low, exactly one bit low at all times.
REQ-007 Port new_key, output, 1: single-cycle strobe marking an accepted key press.
REQ-008 Port key_value, output, 16: one-hot code of the last accepted key, bit index = row*4 + col; feeds the keypress-storage datapath.

Function
REQ-009 rows SHALL pass through a 2-flop synchronizer; all FSM decisions SHALL use the synchronized value srows.
REQ-010 The FSM SHALL have four states: SCAN, DEBOUNCE, HELD, RELEASE.
REQ-011 SCAN: the dwell counter counts 0..SCAN_CYCLES-1 with col held; on the terminal count, if any srows bit is 0 the FSM SHALL latch (row, col) and enter DEBOUNCE; otherwise col advances 0->1->2->3->0 and the counter clears.
REQ-012 If several srows bits are 0 at sampling, the lowest row index SHALL win.
REQ-013 DEBOUNCE: col SHALL be held; the counter counts while srows[latched row] = 0; if that bit reads 1 first, the FSM SHALL return to SCAN with col advanced and no strobe.
REQ-014 DEBOUNCE terminal count (DEBOUNCE_CYCLES-1) with the row still low SHALL enter HELD, pulse new_key for exactly that one cycle, and update key_value in the same cycle.
REQ-015 HELD: col SHALL be held; presses on other rows or columns SHALL be ignored; srows[latched row] = 1 SHALL enter RELEASE with the counter cleared.
REQ-016 RELEASE: if the latched row reads 0 before the terminal count, the FSM SHALL return to HELD with no new strobe (bounce); at terminal count DEBOUNCE_CYCLES-1 it SHALL enter SCAN with col advanced.
REQ-017 key_value SHALL hold its value until the next new_key; it SHALL NOT clear on release.
REQ-018 new_key SHALL never be high on two consecutive cycles; at most one strobe per physical press.
REQ-019 Counters SHALL be $clog2(max(SCAN_CYCLES, DEBOUNCE_CYCLES)) bits and SHALL clear on every state change.
REQ-020 Worst-case latency, row fall to new_key: 2 (sync) + 4*SCAN_CYCLES + DEBOUNCE_CYCLES clocks.

Reset
REQ-021 Asserting reset at any time, including mid-debounce or HELD, SHALL immediately force state = SCAN, cols = 4'b1110, counters = 0, new_key = 0, key_value = 16'h0000, and synchronizer flops = 4'b1111.
REQ-022 After reset deasserts, the first row sample SHALL occur SCAN_CYCLES clocks later, on column 0.

Structure
REQ-023 Package keypad_pkg SHALL hold NUM_ROWS = 4, NUM_COLS = 4, and the state enum typedef (SCAN, DEBOUNCE, HELD, RELEASE).
REQ-024 Sub-module sync2 (parameterized width, async active-high reset to all-ones) SHALL implement REQ-009; everything else SHALL stay in keypad_scan_ctrl.
REQ-025 All outputs SHALL be registered; there SHALL be no combinational path from rows to any output.

Verification (bench overrides SCAN_CYCLES = 4, DEBOUNCE_CYCLES = 8; keypad model pulls row r low when cols[c] = 0 and key (r,c) is pressed)
REQ-026 Idle, no key: cols cycles 1110 -> 1101 -> 1011 -> 0111 -> 1110, 4 clocks per step; new_key stays 0; key_value = 0.
REQ-027 Clean press of key (2,1): exactly one new_key pulse; key_value = 16'h0200; held for 100 clocks -> no further pulse; release -> scanning resumes at col 2.
REQ-028 Bounce: row 0 low for 3 clocks then high during DEBOUNCE -> no strobe, key_value unchanged, scan resumes; a later stable press of (0,3) -> key_value = 16'h0008.
REQ-029 Release bounce: in HELD, (1,0) released for 3 clocks then re-pressed, then released stably -> one strobe total, key_value = 16'h0010.
REQ-030 Simultaneous (1,2) and (3,2) pressed -> key_value = 16'h0040; pressing (0,0) while in HELD -> ignored.
REQ-031 Reset asserted mid-DEBOUNCE -> outputs take REQ-021 values asynchronously, before the next clock edge; no strobe after deassert until a full new debounce completes.
